// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin two-requester arbiter driving a 2:1 mux select, with hold-limit preemption and a registered output
module mux2_arbiter #(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic              req2,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic              gnt1,
  output logic              gnt2,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  output logic              preempt
);
  localparam int CW = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] HMAX = CW'(HOLD_MAX - 1);
  // one-hot grant encoding so gnt1/gnt2 come straight off flops
  typedef enum logic [1:0] {IDLE = 2'b00, GNT1 = 2'b01, GNT2 = 2'b10} state_t;
  state_t state, state_nx;
  logic last, last_nx;
  logic [CW-1:0] hold_cnt, hold_nx;
  logic pre_nx, at_max, entry;
  assign gnt1 = state[0];
  assign gnt2 = state[1];
  assign sel = state[1];
  assign at_max = hold_cnt == HMAX;
  always_comb begin
    state_nx = state;
    pre_nx = 1'b0;
    case (state)
      IDLE: state_nx = (req1 & req2) ? (last ? GNT1 : GNT2) : req1 ? GNT1 : req2 ? GNT2 : IDLE;
      GNT1: begin
        if (!req1) state_nx = req2 ? GNT2 : IDLE;
        else if (req2 && at_max) begin
          state_nx = GNT2;
          pre_nx = 1'b1;
        end
      end
      GNT2: begin
        if (!req2) state_nx = req1 ? GNT1 : IDLE;
        else if (req1 && at_max) begin
          state_nx = GNT1;
          pre_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    entry = (state_nx != state) && (state_nx != IDLE);
    hold_nx = (state_nx == state && state != IDLE) ? (at_max ? hold_cnt : hold_cnt + CW'(1)) : '0;
    // last: 1 means requester 2 was the most recent owner
    last_nx = entry ? (state_nx == GNT2) : last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      hold_cnt <= '0;
      preempt <= 1'b0;
      out_data <= '0;
      out_vld <= 1'b0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      hold_cnt <= hold_nx;
      preempt <= pre_nx;
      out_vld <= (gnt1 & req1) | (gnt2 & req2);
      if ((gnt1 & req1) | (gnt2 & req2)) out_data <= sel ? in2 : in1;
    end
  end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: directed checks of arbitration, preemption, handoff, datapath and async reset
module tb_mux2_arbiter;
  logic clk = 1'b0;
  logic rst_n, req1, req2;
  logic [7:0] in1, in2, out_data;
  logic gnt1, gnt2, sel, out_vld, preempt;
  int total = 0;
  int bad = 0;
  mux2_arbiter #(.DATA_W(8), .HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req1(req1), .req2(req2), .in1(in1), .in2(in2),
    .gnt1(gnt1), .gnt2(gnt2), .sel(sel), .out_data(out_data), .out_vld(out_vld), .preempt(preempt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_g1"}, gnt1, 0);
    chk({tag, "_g2"}, gnt2, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_dat"}, out_data, 0);
    chk({tag, "_vld"}, out_vld, 0);
    chk({tag, "_pre"}, preempt, 0);
  endtask
  initial begin
    rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0; in1 = 8'h11; in2 = 8'h22;
    step;
    step;
    chk_rst("reset");
    rst_n = 1'b1;
    step;
    chk("idle_g1", gnt1, 0);
    // constant contention: 4-cycle turns starting with requester 1
    req1 = 1'b1; req2 = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      bit own1, prev1;
      step;
      own1 = ((c - 1) / 4) % 2 == 0;
      prev1 = ((c - 2) / 4) % 2 == 0;
      chk($sformatf("rr_g1_%0d", c), gnt1, own1);
      chk($sformatf("rr_g2_%0d", c), gnt2, !own1);
      chk($sformatf("rr_sel_%0d", c), sel, !own1);
      chk($sformatf("rr_pre_%0d", c), preempt, c > 1 && (c - 1) % 4 == 0);
      chk($sformatf("rr_vld_%0d", c), out_vld, c > 1);
      if (c > 1) chk($sformatf("rr_dat_%0d", c), out_data, prev1 ? 8'h11 : 8'h22);
    end
    in2 = 8'h3C;
    step;
    chk("own2_dat", out_data, 8'h3C);
    chk("own2_pre", preempt, 0);
    // both drop: idle, data retained
    req1 = 1'b0; req2 = 1'b0; in2 = 8'h77;
    step;
    chk("drop_g1", gnt1, 0);
    chk("drop_g2", gnt2, 0);
    chk("drop_vld", out_vld, 0);
    chk("drop_dat", out_data, 8'h3C);
    step;
    chk("drop2_dat", out_data, 8'h3C);
    // uncontested requester 1 with incrementing data
    req1 = 1'b1; in1 = 8'h10;
    for (int k = 1; k <= 20; k++) begin
      step;
      chk($sformatf("solo_g1_%0d", k), gnt1, 1);
      chk($sformatf("solo_pre_%0d", k), preempt, 0);
      chk($sformatf("solo_vld_%0d", k), out_vld, k > 1);
      if (k > 1) chk($sformatf("solo_dat_%0d", k), out_data, 8'h10 + k - 2);
      if (k > 1) in1 = in1 + 8'h1;
    end
    // handoff at saturated hold count: switch without preempt
    req1 = 1'b0; req2 = 1'b1; in2 = 8'hA5;
    step;
    chk("hand_g1", gnt1, 0);
    chk("hand_g2", gnt2, 1);
    chk("hand_sel", sel, 1);
    chk("hand_pre", preempt, 0);
    chk("hand_vld", out_vld, 0);
    step;
    chk("hand_dat", out_data, 8'hA5);
    chk("hand_vld2", out_vld, 1);
    // release to idle, then contested: requester 1 wins since 2 was last
    req2 = 1'b0;
    step;
    chk("fair_idle", gnt2, 0);
    req1 = 1'b1; req2 = 1'b1;
    step;
    chk("fair_g1", gnt1, 1);
    chk("fair_g2", gnt2, 0);
    for (int c = 2; c <= 5; c++) step;
    chk("pre_g2", gnt2, 1);
    chk("pre_pulse", preempt, 1);
    // async reset mid-GNT2
    #2 rst_n = 1'b0;
    #1 chk_rst("async");
    step;
    chk_rst("held");
    rst_n = 1'b1;
    step;
    chk("rst_g1", gnt1, 1);
    chk("rst_g2", gnt2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
